polarfir_hls_deadlock_report_unit: RTL
======================================

Name: polarFir_hls_deadlock_report_unit

Overview:
- Central collector on the far end of the per-process deadlock detection ring.
- Watches every process's dl_detect_out and confirms a persistent detection.
- Elects one origin process, broadcasts dl_detect_in, launches the trace token from the origin, and records which processes the token visits.
- Issues token_clear when the token returns to the origin, then presents a one-shot deadlock report (origin ID, cycle bitmap, timeout flag) over a valid/ready handshake; one instance per dataflow region.

Parameters:
- PROC_NUM, 4, number of processes in the region (≥2)
- CONFIRM_CYCLES, 16, consecutive cycles a detection must persist before it is declared (≥1)
- TRACE_TIMEOUT, 1024, maximum cycles in TRACE before the report is forced
- ID_W, $clog2(PROC_NUM), width of the process index

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- dl_detect_vec  in  PROC_NUM  bit p = dl_detect_out of process p
- proc_token_vec  in  PROC_NUM  bit p = OR of process p's token_in_vec (token arrived at p this cycle)
- dl_detect_in  out  1  broadcast to all units; high from ORIGIN onward
- origin  out  PROC_NUM  one-hot, one-cycle pulse at the elected process
- token_clear  out  1  one-cycle pulse when the token returns to the origin
- dl_report_valid  out  1  report available
- dl_report_ready  in  1  consumer accepts the report
- dl_report_origin  out  ID_W  elected process index
- dl_report_path  out  PROC_NUM  processes visited by the token, origin bit included
- dl_report_timeout  out  1  trace ended by timeout, not token return
- dl_active  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; path 0. Reset is honoured in every state, including mid-trace and mid-handshake.
- IDLE:
  - |dl_detect_vec increments confirm_cnt; a zero vector clears it.
  - When confirm_cnt reaches CONFIRM_CYCLES-1 with the vector still nonzero, latch org = lowest set index of dl_detect_vec and go to ORIGIN.
  - Detection to ORIGIN takes exactly CONFIRM_CYCLES cycles.
- ORIGIN (1 cycle):
  - origin = 1<<org; dl_detect_in = 1; path = 1<<org; trace_cnt = 0.
  - Next state is TRACE.
- TRACE:
  - dl_detect_in = 1; each cycle path |= proc_token_vec; trace_cnt increments.
  - If proc_token_vec[org] = 1: token_clear = 1 for that cycle, timeout = 0, go to REPORT.
  - Else if trace_cnt reaches TRACE_TIMEOUT-1: timeout = 1, go to REPORT, no token_clear.
  - Token-return check takes priority over timeout in the same cycle.
  - Token arrivals in the cycle of return are included in path.
- REPORT:
  - dl_report_valid = 1; origin/path/timeout are held stable until dl_report_valid && dl_report_ready.
  - On that handshake, go to HOLD.
  - Ready may already be high on entry; the transfer then completes in the first REPORT cycle.
- HOLD (sticky):
  - dl_detect_in = 1, valid = 0, and the report fields keep their values.
  - Exit only via reset, because the deadlocked region cannot recover.
- dl_detect_in is a registered output: high in ORIGIN, TRACE, REPORT and HOLD; low in IDLE.
- origin and token_clear are registered single-cycle pulses and are never asserted in the same cycle.
- dl_detect_vec changes after IDLE are ignored.
- Counters saturate; they never wrap.

Decomposition:
- Package polarFir_hls_deadlock_pkg holds:
  - the state enum (IDLE, ORIGIN, TRACE, REPORT, HOLD)
  - the default CONFIRM_CYCLES and TRACE_TIMEOUT constants
  - a lowest-set-bit function returning ID_W
- Sub-module polarFir_hls_deadlock_prio_enc: a parameterised PROC_NUM→ID_W lowest-index priority encoder with a valid output.
- The FSM, counters and path register stay in the top module.

Test Plan:
- PROC_NUM=4, CONFIRM_CYCLES=4:
  - dl_detect_vec=4'b0100 held 4 cycles → origin=4'b0100 on cycle 5 for 1 cycle, dl_detect_in rises at the same time, dl_active=1.
  - Glitch: dl_detect_vec=4'b0010 for 3 cycles, then 0 for 1 cycle, then 4'b0010 for 4 cycles → origin pulses only after the second run; the first run produces no output.
  - Simultaneous detects 4'b1010 held → dl_report_origin=1 (lowest index).
- Full trace:
  - Origin 2; proc_token_vec pulses 4'b1000, then 4'b0001, then 4'b0100 → token_clear on the third pulse, path=4'b1101, timeout=0.
  - dl_report_valid held while dl_report_ready=0 for 5 cycles; fields stable; one handshake, then HOLD with dl_detect_in=1.
- Timeout: TRACE_TIMEOUT=8, the origin bit never returns → dl_report_timeout=1, token_clear never pulses, path shows only the visited bits.
- Reset: synchronous reset asserted in TRACE, then in REPORT → next cycle all outputs 0 and state IDLE; a fresh detection sequence then completes normally.

Source files
------------

// File: rtl/polarfir_hls_deadlock_report_unit_pkg.sv
// rtl/polarfir_hls_deadlock_report_unit_pkg.sv - shared types and helpers for the deadlock report unit
//
// Purpose: FSM state encoding, default timing constants and a lowest-set-bit
// helper used by the origin priority encoder.
// Ports: none (package).

package polarFir_hls_deadlock_pkg;

  // Upper bound on region size the helper function can scan.
  localparam int MAX_PROC = 64;
  localparam int MAX_ID_W = 6;

  localparam int DEF_CONFIRM_CYCLES = 16;
  localparam int DEF_TRACE_TIMEOUT  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_TRACE  = 3'd2,
    ST_REPORT = 3'd3,
    ST_HOLD   = 3'd4
  } dl_state_e;

  // Index of the lowest set bit; 0 when the vector is empty (callers qualify
  // the result with a separate OR-reduction).
  function automatic logic [MAX_ID_W-1:0] lowest_set(input logic [MAX_PROC-1:0] v);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (v[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/polarfir_hls_deadlock_report_unit_prio_enc.sv
// rtl/polarfir_hls_deadlock_report_unit_prio_enc.sv - lowest-index priority encoder
//
// Purpose: pick the lowest-numbered requesting process as deadlock origin.
// Ports:
//   req_i   [PROC_NUM-1:0]  request vector
//   idx_o   [ID_W-1:0]      index of lowest set request
//   valid_o                 at least one request is set

module polarFir_hls_deadlock_prio_enc
  import polarFir_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = $clog2(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] req_i,
  output logic [ID_W-1:0]     idx_o,
  output logic                valid_o
);

  logic [MAX_PROC-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[PROC_NUM-1:0]  = req_i;
  end

  assign idx_o   = ID_W'(lowest_set(req_ext));
  assign valid_o = |req_i;

endmodule

// File: rtl/polarfir_hls_deadlock_report_unit.sv
// rtl/polarfir_hls_deadlock_report_unit.sv - deadlock confirm/trace/report collector for one dataflow region
//
// Purpose: confirm a persistent deadlock detection, elect the origin, launch
// and follow the trace token, then present a one-shot report and stay in HOLD.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   dl_detect_vec    [P-1:0]     per-process detection flags
//   proc_token_vec   [P-1:0]     token arrival per process
//   dl_detect_in                 broadcast: deadlock confirmed (ORIGIN onward)
//   origin           [P-1:0]     one-cycle one-hot pulse at elected process
//   token_clear                  one-cycle pulse when token returns to origin
//   dl_report_valid/ready        report handshake
//   dl_report_origin [ID_W-1:0]  elected process index
//   dl_report_path   [P-1:0]     processes visited by the token
//   dl_report_timeout            trace ended by timeout
//   dl_active                    not in IDLE

module polarfir_hls_deadlock_report_unit
  import polarFir_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int TRACE_TIMEOUT  = DEF_TRACE_TIMEOUT,
  parameter int ID_W           = $clog2(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] proc_token_vec,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_report_valid,
  input  logic                dl_report_ready,
  output logic [ID_W-1:0]     dl_report_origin,
  output logic [PROC_NUM-1:0] dl_report_path,
  output logic                dl_report_timeout,
  output logic                dl_active
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int TW = $clog2(TRACE_TIMEOUT + 1);

  dl_state_e           state_q;
  logic [CW-1:0]       confirm_cnt_q, confirm_cnt_d;
  logic [TW-1:0]       trace_cnt_q, trace_cnt_d;
  logic [ID_W-1:0]     org_q;
  logic [PROC_NUM-1:0] path_q, path_d;
  logic [PROC_NUM-1:0] origin_q;
  logic                dl_detect_in_q;
  logic                token_clear_q;
  logic                valid_q;
  logic                timeout_q;

  logic [ID_W-1:0]     enc_idx;
  logic                enc_valid;
  logic [PROC_NUM-1:0] enc_onehot;
  logic                tok_ret;
  logic                confirm_hit;
  logic                trace_expired;

  polarFir_hls_deadlock_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .req_i   (dl_detect_vec),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    enc_onehot    = PROC_NUM'(1) << enc_idx;
    path_d        = path_q | proc_token_vec;
    tok_ret       = proc_token_vec[org_q];
    confirm_hit   = (confirm_cnt_q == CW'(CONFIRM_CYCLES - 1));
    trace_expired = (trace_cnt_q == TW'(TRACE_TIMEOUT - 1));
    // Counters hold at their ceiling instead of wrapping.
    confirm_cnt_d = (confirm_cnt_q == CW'(CONFIRM_CYCLES)) ? confirm_cnt_q
                                                           : confirm_cnt_q + CW'(1);
    trace_cnt_d   = (trace_cnt_q == TW'(TRACE_TIMEOUT)) ? trace_cnt_q
                                                        : trace_cnt_q + TW'(1);
  end

  // Outputs are registered alongside the state so that each pulse lines up
  // with the cycle the FSM spends in the corresponding state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      confirm_cnt_q  <= '0;
      trace_cnt_q    <= '0;
      org_q          <= '0;
      path_q         <= '0;
      origin_q       <= '0;
      dl_detect_in_q <= 1'b0;
      token_clear_q  <= 1'b0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      origin_q      <= '0;
      token_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            if (confirm_hit) begin
              state_q        <= ST_ORIGIN;
              org_q          <= enc_idx;
              origin_q       <= enc_onehot;
              path_q         <= enc_onehot;
              dl_detect_in_q <= 1'b1;
              trace_cnt_q    <= '0;
              confirm_cnt_q  <= '0;
            end else begin
              confirm_cnt_q <= confirm_cnt_d;
            end
          end else begin
            confirm_cnt_q <= '0;
          end
        end
        ST_ORIGIN: begin
          trace_cnt_q <= '0;
          state_q     <= ST_TRACE;
        end
        ST_TRACE: begin
          // Arrivals in the return cycle still belong to the path.
          path_q <= path_d;
          if (tok_ret) begin
            token_clear_q <= 1'b1;
            timeout_q     <= 1'b0;
            valid_q       <= 1'b1;
            state_q       <= ST_REPORT;
          end else if (trace_expired) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= ST_REPORT;
          end else begin
            trace_cnt_q <= trace_cnt_d;
          end
        end
        ST_REPORT: begin
          if (dl_report_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Deadlocked region never recovers; only reset leaves HOLD.
          state_q <= ST_HOLD;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dl_detect_in      = dl_detect_in_q;
  assign origin            = origin_q;
  assign token_clear       = token_clear_q;
  assign dl_report_valid   = valid_q;
  assign dl_report_origin  = org_q;
  assign dl_report_path    = path_q;
  assign dl_report_timeout = timeout_q;
  assign dl_active         = (state_q != ST_IDLE);

endmodule
